ultrasonic_range: RTL and testbench
===================================

ULTRASONIC_RANGE -- requirements
Module: ultrasonic_range

Interface
REQ-001 Parameter MM_SCALE, 11239, Q16 factor raw-us to mm (343 m/s, round trip).
REQ-002 Parameter MAX_RAW, 38000, largest raw count treated as a real echo.
REQ-003 clk100  input  1  system clock; single clock domain.
REQ-004 rstn  input  1  asynchronous, active-low reset.
REQ-005 trig  input  1  upstream trigger pulse, asynchronous to clk100, used as the frame strobe.
REQ-006 ultra_value_0/1/2  input  32 each  upstream echo widths in us, stable while trig is high.
REQ-007 thresh_mm  input  16  proximity threshold in mm.
REQ-008 dist_mm_0/1/2  output  16 each  filtered distance in mm.
REQ-009 oor_0/1/2  output  1 each  latest sample out of range.
REQ-010 near_0/1/2  output  1 each  filtered distance below threshold.
REQ-011 dist_valid  output  1  one-cycle pulse when outputs update.

Function
REQ-012 trig SHALL pass through a 2-flop synchroniser; a rising edge of the synchronised signal is the frame event.
REQ-013 The FSM SHALL have states IDLE, LATCH, MUL0, MUL1, MUL2, AVG and DONE, each lasting exactly one cycle except IDLE.
REQ-014 IDLE->LATCH on the frame event; LATCH captures all three ultra_value inputs; MULk converts channel k through one shared multiplier; AVG updates the filters; DONE->IDLE.
REQ-015 Frame events outside IDLE SHALL be ignored, with no queueing.
REQ-016 Conversion SHALL be mm = (raw * MM_SCALE) >> 16, truncated, using a 48-bit product and keeping bits [31:16].
REQ-017 raw == 0 or raw > MAX_RAW SHALL set oor_k=1 for that frame, leave that channel's filter history unchanged and leave dist_mm_k unchanged.
REQ-018 An in-range raw value SHALL clear oor_k and push mm into the channel's 4-entry history.
REQ-019 dist_mm_k SHALL equal (sum of the 4 entries) >> 2 (18-bit sum, truncated).
REQ-020 The first in-range sample after reset SHALL fill all 4 history entries (priming); a per-channel primed flag records this.
REQ-021 near_k SHALL equal primed_k && (dist_mm_k < thresh_mm), with thresh_mm sampled in AVG.
REQ-022 dist_mm_k, oor_k and near_k SHALL be registered in AVG and visible from DONE onward, then hold until the next frame.
REQ-023 dist_valid SHALL be high exactly during DONE, i.e. 6 cycles after the frame-event cycle.
REQ-024 dist_valid SHALL pulse every frame, even when all channels are out of range.

Reset
REQ-025 rstn low SHALL immediately clear all state, even mid-frame: FSM to IDLE, synchroniser, history, primed flags, dist_mm_k=0, oor_k=0, near_k=0, dist_valid=0.
REQ-026 After rstn deasserts, the first frame event SHALL be processed normally; any partial frame is discarded.

Configuration
REQ-027 Macro ULTRASONIC_AVG_EN defined: the 4-tap average is compiled in as described above.
REQ-028 ULTRASONIC_AVG_EN undefined: no history or primed logic; dist_mm_k is the latest in-range mm; near_k = (dist_mm_k != 0) && (dist_mm_k < thresh_mm); all timing is identical.

Structure
REQ-029 Shared package ultrasonic_pkg SHALL hold the FSM state typedef, MM_SCALE and MAX_RAW defaults, and the mm width constant (16).
REQ-030 Sub-module ultrasonic_avg4 (history, sum, primed flag, one push port) SHALL be instantiated once per channel.

Verification
REQ-031 Reset, then raw0=1000 with a trig pulse -> dist_valid 6 cycles after the edge; dist_mm_0=171, oor_0=0.
REQ-032 raw0=1000, then raw0=2000 on the next frame -> dist_mm_0=213 (histories {342,171,171,171}).
REQ-033 raw1=38001 and raw2=0 after priming to 171 -> oor_1=oor_2=1; dist_mm_1 and dist_mm_2 stay 171; dist_valid still pulses.
REQ-034 raw0=5831, thresh_mm=1000 -> dist_mm_0=999, near_0=1; thresh_mm=999 -> near_0=0.
REQ-035 Second trig edge arriving during MUL1 -> ignored, exactly one dist_valid pulse; rstn low during MUL0 -> all outputs 0 immediately, and the next frame with raw0=38000 gives 6516.
REQ-036 With ULTRASONIC_AVG_EN undefined, raw0=1000 then 2000 -> dist_mm_0=171 then 342.

Source files
------------

// File: rtl/ultrasonic_pkg.sv
// Shared definitions for the ultrasonic range block: frame FSM states,
// conversion defaults and the distance width.
package ultrasonic_pkg;

    // Q16 factor turning a round-trip echo width in us into mm at 343 m/s.
    localparam int unsigned MM_SCALE_DEFAULT = 11239;
    // Largest raw echo width still treated as a real echo.
    localparam int unsigned MAX_RAW_DEFAULT  = 38000;
    // Width of every distance / threshold value in mm.
    localparam int unsigned MM_W             = 16;

    typedef enum logic [2:0] {
        IDLE,
        LATCH,
        MUL0,
        MUL1,
        MUL2,
        AVG,
        DONE
    } state_t;

endpackage

// File: rtl/ultrasonic_range_if.sv
// Result bundle of the ultrasonic range block: filtered distances,
// out-of-range and proximity flags, plus the update strobe.
interface ultrasonic_range_if;
    import ultrasonic_pkg::*;

    logic [MM_W-1:0] dist_mm_0;
    logic [MM_W-1:0] dist_mm_1;
    logic [MM_W-1:0] dist_mm_2;
    logic            oor_0;
    logic            oor_1;
    logic            oor_2;
    logic            near_0;
    logic            near_1;
    logic            near_2;
    logic            dist_valid;

    modport master (
        output dist_mm_0, dist_mm_1, dist_mm_2,
        output oor_0, oor_1, oor_2,
        output near_0, near_1, near_2,
        output dist_valid
    );

    modport slave (
        input dist_mm_0, dist_mm_1, dist_mm_2,
        input oor_0, oor_1, oor_2,
        input near_0, near_1, near_2,
        input dist_valid
    );

endinterface

// File: rtl/ultrasonic_avg4.sv
// Per-channel 4-entry distance history with priming flag. Only built when
// ULTRASONIC_AVG_EN is defined. avg_push is the average the history would
// hold if din were pushed now, so the caller can register it in the same
// cycle the push happens.
`ifdef ULTRASONIC_AVG_EN
module ultrasonic_avg4
    import ultrasonic_pkg::*;
(
    input  logic            clk100,
    input  logic            rstn,
    input  logic            push,
    input  logic [MM_W-1:0] din,
    output logic [MM_W-1:0] avg_push,
    output logic            primed
);

    localparam int unsigned SUM_W = MM_W + 2;

    logic [MM_W-1:0]  hist      [4];
    logic [MM_W-1:0]  hist_next [4];
    logic [SUM_W-1:0] sum;
    logic             unused_sum_lsbs;

    // Candidate history after a push: shift in din, or fill every tap with
    // din when this is the first sample since reset.
    always_comb begin
        hist_next[0] = din;
        for (int i = 1; i < 4; i++) begin
            hist_next[i] = primed ? hist[i-1] : din;
        end
        sum = SUM_W'(hist_next[0]) + SUM_W'(hist_next[1])
            + SUM_W'(hist_next[2]) + SUM_W'(hist_next[3]);
    end

    assign avg_push        = sum[SUM_W-1:2];
    assign unused_sum_lsbs = ^sum[1:0];

    // History and primed flag update only on a push.
    // NOTE: the history is reset explicitly; a reset mid-frame must leave
    // no stale taps, so this small array is not left to power-up values.
    always_ff @(posedge clk100 or negedge rstn) begin
        if (!rstn) begin
            for (int i = 0; i < 4; i++) hist[i] <= '0;
            primed <= 1'b0;
        end else if (push) begin
            for (int i = 0; i < 4; i++) hist[i] <= hist_next[i];
            primed <= 1'b1;
        end
    end

endmodule
`endif

// File: rtl/ultrasonic_range.sv
// Ultrasonic range front end: synchronises the trig frame strobe, latches
// three echo widths, converts each to mm through one shared multiplier and
// publishes distance / out-of-range / proximity results once per frame.
// Macro ULTRASONIC_AVG_EN: when defined, each channel is smoothed by a
// 4-tap average (ultrasonic_avg4); otherwise the latest in-range mm is used.
module ultrasonic_range
    import ultrasonic_pkg::*;
#(
    parameter int unsigned MM_SCALE = MM_SCALE_DEFAULT,
    parameter int unsigned MAX_RAW  = MAX_RAW_DEFAULT
) (
    input  logic            clk100,
    input  logic            rstn,
    input  logic            trig,
    input  logic [31:0]     ultra_value_0,
    input  logic [31:0]     ultra_value_1,
    input  logic [31:0]     ultra_value_2,
    input  logic [MM_W-1:0] thresh_mm,
    ultrasonic_range_if.master res
);

    state_t          state, state_next;
    logic [2:0]      trig_sync;
    logic            frame_evt;
    logic [31:0]     raw_q    [3];
    logic [MM_W-1:0] mm_q     [3];
    logic [MM_W-1:0] dist_q   [3];
    logic [MM_W-1:0] dist_new [3];
    logic [2:0]      oor_q, oor_out, near_q, near_new;
    logic [31:0]     raw_sel;
    logic [47:0]     product;
    logic [MM_W-1:0] mm_conv;
    logic            oor_conv;
    logic            unused_product_bits;

    // Two-flop synchroniser on trig plus one stage for rising-edge detect.
    // NOTE: sequential state uses non-blocking assignments so every flop
    // samples the pre-edge value of its neighbour.
    always_ff @(posedge clk100 or negedge rstn) begin
        if (!rstn) trig_sync <= '0;
        else       trig_sync <= {trig_sync[1:0], trig};
    end

    assign frame_evt = trig_sync[1] & ~trig_sync[2];

    // FSM state register.
    always_ff @(posedge clk100 or negedge rstn) begin
        if (!rstn) state <= IDLE;
        else       state <= state_next;
    end

    // Next state: one cycle per stage; frame events outside IDLE are dropped.
    // NOTE: state_next gets a default before the case so no latch is inferred.
    always_comb begin
        state_next = state;
        case (state)
            IDLE:    if (frame_evt) state_next = LATCH;
            LATCH:   state_next = MUL0;
            MUL0:    state_next = MUL1;
            MUL1:    state_next = MUL2;
            MUL2:    state_next = AVG;
            AVG:     state_next = DONE;
            DONE:    state_next = IDLE;
            default: state_next = IDLE;
        endcase
    end

    // Route the channel being converted to the shared multiplier.
    always_comb begin
        raw_sel = raw_q[0];
        case (state)
            MUL1:    raw_sel = raw_q[1];
            MUL2:    raw_sel = raw_q[2];
            default: raw_sel = raw_q[0];
        endcase
    end

    assign product             = 48'(raw_sel) * 48'(MM_SCALE);
    assign mm_conv             = product[31:16];
    assign oor_conv            = (raw_sel == 32'd0) || (raw_sel > 32'(MAX_RAW));
    assign unused_product_bits = ^{product[47:32], product[15:0]};

`ifdef ULTRASONIC_AVG_EN
    logic [MM_W-1:0] avg_push [3];
    logic [2:0]      primed, push;

    for (genvar k = 0; k < 3; k++) begin : g_avg
        assign push[k] = (state == AVG) && !oor_q[k];
        ultrasonic_avg4 u_avg4 (
            .clk100   (clk100),
            .rstn     (rstn),
            .push     (push[k]),
            .din      (mm_q[k]),
            .avg_push (avg_push[k]),
            .primed   (primed[k])
        );
    end

    // Filtered result: averaged value for in-range channels, held otherwise.
    always_comb begin
        for (int k = 0; k < 3; k++) begin
            dist_new[k] = oor_q[k] ? dist_q[k] : avg_push[k];
            near_new[k] = (primed[k] | ~oor_q[k]) & (dist_new[k] < thresh_mm);
        end
    end
`else
    // Unfiltered result: latest in-range value, held for out-of-range frames.
    always_comb begin
        for (int k = 0; k < 3; k++) begin
            dist_new[k] = oor_q[k] ? dist_q[k] : mm_q[k];
            near_new[k] = (dist_new[k] != '0) & (dist_new[k] < thresh_mm);
        end
    end
`endif

    // Frame datapath: latch raws, convert one channel per MUL state, and
    // publish all results together in AVG.
    always_ff @(posedge clk100 or negedge rstn) begin
        if (!rstn) begin
            for (int k = 0; k < 3; k++) begin
                raw_q[k]  <= '0;
                mm_q[k]   <= '0;
                dist_q[k] <= '0;
            end
            oor_q   <= '0;
            oor_out <= '0;
            near_q  <= '0;
        end else begin
            case (state)
                LATCH: begin
                    raw_q[0] <= ultra_value_0;
                    raw_q[1] <= ultra_value_1;
                    raw_q[2] <= ultra_value_2;
                end
                MUL0: begin mm_q[0] <= mm_conv; oor_q[0] <= oor_conv; end
                MUL1: begin mm_q[1] <= mm_conv; oor_q[1] <= oor_conv; end
                MUL2: begin mm_q[2] <= mm_conv; oor_q[2] <= oor_conv; end
                AVG: begin
                    for (int k = 0; k < 3; k++) dist_q[k] <= dist_new[k];
                    oor_out <= oor_q;
                    near_q  <= near_new;
                end
                default: ;
            endcase
        end
    end

    assign res.dist_mm_0  = dist_q[0];
    assign res.dist_mm_1  = dist_q[1];
    assign res.dist_mm_2  = dist_q[2];
    assign res.oor_0      = oor_out[0];
    assign res.oor_1      = oor_out[1];
    assign res.oor_2      = oor_out[2];
    assign res.near_0     = near_q[0];
    assign res.near_1     = near_q[1];
    assign res.near_2     = near_q[2];
    assign res.dist_valid = (state == DONE);

endmodule

// File: tb/tb_ultrasonic_range.sv
// Directed bench for ultrasonic_range. Expected values are hand-computed
// from mm = (raw * 11239) >> 16; the averaged / unaveraged build is selected
// with ULTRASONIC_AVG_EN, matching the RTL.
module tb_ultrasonic_range;
    import ultrasonic_pkg::*;

`ifdef ULTRASONIC_AVG_EN
    localparam bit AVG_EN = 1'b1;
`else
    localparam bit AVG_EN = 1'b0;
`endif

    logic        clk100 = 1'b0;
    logic        rstn   = 1'b0;
    logic        trig   = 1'b0;
    logic [31:0] uv0 = '0, uv1 = '0, uv2 = '0;
    logic [15:0] thresh_mm = '0;

    int checks = 0;
    int errors = 0;

    ultrasonic_range_if res ();

    ultrasonic_range dut (
        .clk100        (clk100),
        .rstn          (rstn),
        .trig          (trig),
        .ultra_value_0 (uv0),
        .ultra_value_1 (uv1),
        .ultra_value_2 (uv2),
        .thresh_mm     (thresh_mm),
        .res           (res)
    );

    always #5 clk100 = ~clk100;

    // One trig pulse; reports the cycle of the first dist_valid and pulse count.
    task automatic do_frame(output int first, output int pulses);
        @(negedge clk100);
        trig   = 1'b1;
        first  = 0;
        pulses = 0;
        for (int i = 1; i <= 14; i++) begin
            @(posedge clk100);
            @(negedge clk100);
            if (i == 3) trig = 1'b0;
            if (res.dist_valid) begin
                pulses++;
                if (first == 0) first = i;
            end
        end
    endtask

    task automatic pulse_reset();
        @(negedge clk100);
        rstn = 1'b0;
        repeat (2) @(negedge clk100);
        rstn = 1'b1;
    endtask

    task automatic test_reset();
        rstn = 1'b0;
        repeat (3) @(negedge clk100);
        checks++; if (res.dist_mm_0 !== 16'd0) begin errors++; $display("FAIL reset_dist0: got %0d expected 0", res.dist_mm_0); end
        checks++; if ({res.oor_0, res.oor_1, res.oor_2} !== 3'b000) begin errors++; $display("FAIL reset_oor: got %b expected 000", {res.oor_0, res.oor_1, res.oor_2}); end
        checks++; if (res.dist_valid !== 1'b0) begin errors++; $display("FAIL reset_valid: got %b expected 0", res.dist_valid); end
        rstn = 1'b1;
    endtask

    task automatic test_first_frame();
        int first, pulses;
        uv0 = 1000; uv1 = 1000; uv2 = 1000; thresh_mm = 0;
        do_frame(first, pulses);
        checks++; if (first !== 8) begin errors++; $display("FAIL valid_latency: got cycle %0d expected 8", first); end
        checks++; if (pulses !== 1) begin errors++; $display("FAIL first_pulses: got %0d expected 1", pulses); end
        checks++; if (res.dist_mm_0 !== 16'd171) begin errors++; $display("FAIL first_dist0: got %0d expected 171", res.dist_mm_0); end
        checks++; if (res.dist_mm_2 !== 16'd171) begin errors++; $display("FAIL first_dist2: got %0d expected 171", res.dist_mm_2); end
        checks++; if (res.oor_0 !== 1'b0) begin errors++; $display("FAIL first_oor0: got %b expected 0", res.oor_0); end
        checks++; if (res.near_0 !== 1'b0) begin errors++; $display("FAIL first_near0: got %b expected 0", res.near_0); end
    endtask

    task automatic test_average();
        int first, pulses, exp0;
        uv0 = 2000; uv1 = 1000; uv2 = 1000;
        exp0 = AVG_EN ? 213 : 342;
        do_frame(first, pulses);
        checks++; if (res.dist_mm_0 !== 16'(exp0)) begin errors++; $display("FAIL avg_dist0: got %0d expected %0d", res.dist_mm_0, exp0); end
        checks++; if (res.dist_mm_1 !== 16'd171) begin errors++; $display("FAIL avg_dist1: got %0d expected 171", res.dist_mm_1); end
    endtask

    task automatic test_out_of_range();
        int first, pulses, exp0;
        uv0 = 2000; uv1 = 38001; uv2 = 0;
        exp0 = AVG_EN ? 256 : 342;
        do_frame(first, pulses);
        checks++; if (pulses !== 1) begin errors++; $display("FAIL oor_pulses: got %0d expected 1", pulses); end
        checks++; if ({res.oor_0, res.oor_1, res.oor_2} !== 3'b011) begin errors++; $display("FAIL oor_flags: got %b expected 011", {res.oor_0, res.oor_1, res.oor_2}); end
        checks++; if (res.dist_mm_1 !== 16'd171) begin errors++; $display("FAIL oor_hold1: got %0d expected 171", res.dist_mm_1); end
        checks++; if (res.dist_mm_2 !== 16'd171) begin errors++; $display("FAIL oor_hold2: got %0d expected 171", res.dist_mm_2); end
        checks++; if (res.dist_mm_0 !== 16'(exp0)) begin errors++; $display("FAIL oor_dist0: got %0d expected %0d", res.dist_mm_0, exp0); end
        uv0 = 0; uv1 = 0; uv2 = 0;
        do_frame(first, pulses);
        checks++; if (pulses !== 1) begin errors++; $display("FAIL all_oor_pulses: got %0d expected 1", pulses); end
        checks++; if ({res.oor_0, res.oor_1, res.oor_2} !== 3'b111) begin errors++; $display("FAIL all_oor_flags: got %b expected 111", {res.oor_0, res.oor_1, res.oor_2}); end
        checks++; if (res.dist_mm_0 !== 16'(exp0)) begin errors++; $display("FAIL all_oor_hold0: got %0d expected %0d", res.dist_mm_0, exp0); end
    endtask

    task automatic test_threshold();
        int first, pulses;
        pulse_reset();
        uv0 = 5831; uv1 = 0; uv2 = 0; thresh_mm = 1000;
        do_frame(first, pulses);
        checks++; if (res.dist_mm_0 !== 16'd999) begin errors++; $display("FAIL thr_dist0: got %0d expected 999", res.dist_mm_0); end
        checks++; if (res.near_0 !== 1'b1) begin errors++; $display("FAIL thr_near0_1000: got %b expected 1", res.near_0); end
        checks++; if (res.near_1 !== 1'b0) begin errors++; $display("FAIL thr_near1_unprimed: got %b expected 0", res.near_1); end
        thresh_mm = 999;
        do_frame(first, pulses);
        checks++; if (res.dist_mm_0 !== 16'd999) begin errors++; $display("FAIL thr_dist0_b: got %0d expected 999", res.dist_mm_0); end
        checks++; if (res.near_0 !== 1'b0) begin errors++; $display("FAIL thr_near0_999: got %b expected 0", res.near_0); end
    endtask

    task automatic test_back_to_back();
        int first, pulses, exp0;
        uv0 = 1000; uv1 = 0; uv2 = 0;
        exp0 = AVG_EN ? 792 : 171;
        first = 0; pulses = 0;
        @(negedge clk100);
        trig = 1'b1;
        for (int i = 1; i <= 20; i++) begin
            @(posedge clk100);
            @(negedge clk100);
            if (i == 2) trig = 1'b0;
            if (i == 5) trig = 1'b1;   // lands on the pin during MUL1
            if (i == 7) trig = 1'b0;
            if (res.dist_valid) begin
                pulses++;
                if (first == 0) first = i;
            end
        end
        checks++; if (pulses !== 1) begin errors++; $display("FAIL b2b_pulses: got %0d expected 1", pulses); end
        checks++; if (first !== 8) begin errors++; $display("FAIL b2b_latency: got cycle %0d expected 8", first); end
        checks++; if (res.dist_mm_0 !== 16'(exp0)) begin errors++; $display("FAIL b2b_dist0: got %0d expected %0d", res.dist_mm_0, exp0); end
    endtask

    task automatic test_reset_mid_frame();
        int first, pulses;
        uv0 = 38000; uv1 = 0; uv2 = 0;
        @(negedge clk100);
        trig = 1'b1;
        for (int i = 1; i <= 4; i++) begin
            @(posedge clk100);
            @(negedge clk100);
            if (i == 3) trig = 1'b0;
        end
        rstn = 1'b0;               // state is MUL0 here
        #1;
        checks++; if (res.dist_mm_0 !== 16'd0) begin errors++; $display("FAIL midrst_dist0: got %0d expected 0", res.dist_mm_0); end
        checks++; if (res.oor_1 !== 1'b0) begin errors++; $display("FAIL midrst_oor1: got %b expected 0", res.oor_1); end
        checks++; if (res.near_0 !== 1'b0) begin errors++; $display("FAIL midrst_near0: got %b expected 0", res.near_0); end
        checks++; if (res.dist_valid !== 1'b0) begin errors++; $display("FAIL midrst_valid: got %b expected 0", res.dist_valid); end
        @(negedge clk100);
        rstn = 1'b1;
        do_frame(first, pulses);
        checks++; if (first !== 8) begin errors++; $display("FAIL post_rst_latency: got cycle %0d expected 8", first); end
        checks++; if (res.dist_mm_0 !== 16'd6516) begin errors++; $display("FAIL post_rst_dist0: got %0d expected 6516", res.dist_mm_0); end
        checks++; if (res.oor_0 !== 1'b0) begin errors++; $display("FAIL post_rst_oor0: got %b expected 0", res.oor_0); end
    endtask

    initial begin
        test_reset();
        test_first_frame();
        test_average();
        test_out_of_range();
        test_threshold();
        test_back_to_back();
        test_reset_mid_frame();
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
